fp_to_int: RTL and testbench
============================

Name: fp_to_int

Overview:
- Converts an IEEE-754 single-precision float to a 32-bit integer, rounding toward zero.
- Sits directly downstream of the FPU adder: its input port connects to the adder's output_z/output_z_stb/output_z_ack.
- Its result feeds the integer writeback path.
- Uses the same stb/ack handshake on both sides. Semantics match RISC-V fcvt.w.s / fcvt.wu.s with rm=RTZ.

Parameters:
- OUT_UNSIGNED, 0: 0 = signed (fcvt.w.s), 1 = unsigned (fcvt.wu.s).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-low reset (sampled on the clk rising edge).
- input_a  in  32  float operand.
- input_a_stb  in  1  producer has valid input_a.
- input_a_ack  out  1  block accepts input_a.
- output_z  out  32  integer result.
- output_z_nv  out  1  invalid flag, valid with output_z.
- output_z_nx  out  1  inexact flag, valid with output_z.
- output_z_stb  out  1  result valid.
- output_z_ack  in  1  consumer has taken the result.

Behaviour:
- Reset (rst=0 at an edge, in any state, including mid-conversion or while output_z_stb=1):
  - state goes to GET_A;
  - input_a_ack, output_z_stb, output_z, output_z_nv and output_z_nx all go to 0;
  - any operation in flight is discarded.
- FSM: GET_A -> UNPACK -> SPECIAL -> CONVERT -> PUT_Z -> GET_A. All outputs are registered.
- GET_A:
  - input_a_ack=1 from the first edge after entry.
  - Transfer occurs at the edge where input_a_stb && input_a_ack. At that edge input_a is latched, ack goes to 0 and the FSM moves to UNPACK.
- UNPACK: splits the operand into sign s, exponent e = exp - 127, and 24-bit magnitude m = {exp!=0, frac}.
- SPECIAL: classifies the operand as NaN, Inf, zero/denormal, |v|<1, overflow or normal, and precomputes the saturation value.
- CONVERT:
  - Normal case: if e>=23, r = m << (e-23); otherwise r = m >> (23-e).
  - nx=1 if any bits shifted out are non-zero.
  - Signed mode with s=1: r = -r (two's complement).
- PUT_Z: output_z_stb=1; output_z and flags are held stable until the edge where output_z_ack=1. At that edge stb goes to 0 and the FSM returns to GET_A.
- Latency and throughput:
  - output_z_stb rises 4 edges after the accepting edge.
  - If ack is already high, stb lasts one cycle.
  - At most one operation in flight.
  - input_a_ack is re-asserted one edge after the stb/ack handshake completes.
- Signed (OUT_UNSIGNED=0):
  - NaN (exp=255, frac!=0): 0x7FFFFFFF, nv=1.
  - +Inf, or e>=31 with s=0: 0x7FFFFFFF, nv=1.
  - -Inf, or e>=31 with s=1, except exactly -2^31: 0x80000000, nv=1.
  - Exactly -2^31 (0xCF000000): 0x80000000, no flags.
  - +/-0 and denormals: 0. Zero sets no flags; a denormal sets nx=1.
  - e<0: 0, nx=1.
- Unsigned (OUT_UNSIGNED=1):
  - NaN, +Inf, or e>=32 with s=0: 0xFFFFFFFF, nv=1.
  - s=1 and e>=0, or -Inf: 0, nv=1.
  - s=1 and e<0 (non-zero): 0, nx=1.
  - -0.0: 0, no flags.
  - Otherwise, magnitude shifted as in the normal case, no negation.
- nv and nx are never both 1.
- input_a_stb changing while ack=0 has no effect.
- output_z_ack asserted outside PUT_Z is ignored.

Test Plan:
- Signed, 0x40000000 (2.0), ack held high -> output_z=0x00000002, nv=0, nx=0; stb rises exactly 4 edges after acceptance and is high for 1 cycle.
- Signed, 0xC0200000 (-2.5) -> 0xFFFFFFFE, nx=1. Then 0xCF000000 -> 0x80000000, nv=0, nx=0.
- Signed, 0x4F32D05E (~3.0e9) -> 0x7FFFFFFF, nv=1. Then 0x7FC00000 (NaN) -> 0x7FFFFFFF, nv=1. Then 0x00000001 (denormal) -> 0, nx=1.
- Unsigned, 0x4F32D05E -> 0xB2D05E00, no flags. Then 0xBF800000 (-1.0) -> 0, nv=1. Then 0xBF000000 (-0.5) -> 0, nx=1.
- Backpressure: hold output_z_ack=0 for 10 cycles -> output_z_stb, output_z and flags stay stable and input_a_ack stays 0. Ack for 1 cycle -> stb=0 the next edge, input_a_ack=1 one edge later.
- Reset mid-operation: drive rst=0 one edge after acceptance -> all outputs 0 and state GET_A. After release, input_a_ack=1 at the next edge, and a new 1.0 (0x3F800000) converts to 0x00000001.

Source files
------------

// File: rtl/fp_to_int.sv
// rtl/fp_to_int.sv - IEEE-754 single to 32-bit integer converter, round toward zero, stb/ack handshake
module fp_to_int #(
   parameter bit OUT_UNSIGNED = 1'b0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] input_a,
   input  logic        input_a_stb,
   output logic        input_a_ack,
   output logic [31:0] output_z,
   output logic        output_z_nv,
   output logic        output_z_nx,
   output logic        output_z_stb,
   input  logic        output_z_ack
);

   typedef enum logic [2:0] {GET_A, UNPACK, SPECIAL, CONVERT, PUT_Z} state_t;

   state_t             state, state_n;
   logic [31:0]        a, a_n;
   logic               s, s_n;
   logic signed [9:0]  e, e_n;
   logic [23:0]        m, m_n;
   logic               special, special_n;
   logic [31:0]        sat_val, sat_val_n;
   logic               sat_nv, sat_nv_n;
   logic               sat_nx, sat_nx_n;
   logic               ack_n, stb_n, nv_n, nx_n;
   logic [31:0]        z_n;

   logic               ge23;
   logic [4:0]         sh;
   logic [31:0]        mag, norm_r, lost_mask;
   logic               norm_nx;

   // Normal-range magnitude: left shift when the exponent reaches the fraction width, else truncate
   always_comb begin
      ge23      = (e >= 10'sd23);
      sh        = ge23 ? (e[4:0] - 5'd23) : (5'd23 - e[4:0]);
      mag       = {8'd0, m};
      lost_mask = (32'd1 << sh) - 32'd1;
      norm_r    = ge23 ? (mag << sh) : (mag >> sh);
      norm_nx   = ge23 ? 1'b0 : |(mag & lost_mask);
   end

   // Next-state and next-register values for the whole pipeline of phases
   always_comb begin
      state_n   = state;
      a_n       = a;
      s_n       = s;
      e_n       = e;
      m_n       = m;
      special_n = special;
      sat_val_n = sat_val;
      sat_nv_n  = sat_nv;
      sat_nx_n  = sat_nx;
      ack_n     = input_a_ack;
      stb_n     = output_z_stb;
      z_n       = output_z;
      nv_n      = output_z_nv;
      nx_n      = output_z_nx;
      unique case (state)
         GET_A: begin
            ack_n = 1'b1;
            if (input_a_stb && input_a_ack) begin
               a_n     = input_a;
               ack_n   = 1'b0;
               state_n = UNPACK;
            end
         end
         UNPACK: begin
            s_n     = a[31];
            e_n     = $signed({2'b00, a[30:23]}) - 10'sd127;
            m_n     = {(a[30:23] != 8'd0), a[22:0]};
            state_n = SPECIAL;
         end
         SPECIAL: begin
            special_n = 1'b1;
            sat_val_n = 32'd0;
            sat_nv_n  = 1'b0;
            sat_nx_n  = 1'b0;
            if (a[30:23] == 8'hFF) begin
               sat_nv_n = 1'b1;
               if (a[22:0] != 23'd0 || !s)
                  sat_val_n = OUT_UNSIGNED ? 32'hFFFF_FFFF : 32'h7FFF_FFFF;
               else
                  sat_val_n = OUT_UNSIGNED ? 32'h0000_0000 : 32'h8000_0000;
            end else if (a[30:23] == 8'd0) begin
               // Zero is exact; a denormal truncates to zero inexactly
               sat_nx_n = (a[22:0] != 23'd0);
            end else if (e < 10'sd0) begin
               sat_nx_n = 1'b1;
            end else if (OUT_UNSIGNED) begin
               if (s) begin
                  sat_nv_n = 1'b1;
               end else if (e >= 10'sd32) begin
                  sat_nv_n  = 1'b1;
                  sat_val_n = 32'hFFFF_FFFF;
               end else begin
                  special_n = 1'b0;
               end
            end else begin
               if (e >= 10'sd31) begin
                  // -2^31 is the one value at this magnitude that is representable
                  if (a == 32'hCF00_0000) begin
                     sat_val_n = 32'h8000_0000;
                  end else begin
                     sat_nv_n  = 1'b1;
                     sat_val_n = s ? 32'h8000_0000 : 32'h7FFF_FFFF;
                  end
               end else begin
                  special_n = 1'b0;
               end
            end
            state_n = CONVERT;
         end
         CONVERT: begin
            if (special) begin
               z_n  = sat_val;
               nv_n = sat_nv;
               nx_n = sat_nx;
            end else begin
               z_n  = (!OUT_UNSIGNED && s) ? -norm_r : norm_r;
               nv_n = 1'b0;
               nx_n = norm_nx;
            end
            state_n = PUT_Z;
         end
         PUT_Z: begin
            if (!output_z_stb) begin
               stb_n = 1'b1;
            end else if (output_z_ack) begin
               stb_n   = 1'b0;
               state_n = GET_A;
            end
         end
         default: state_n = GET_A;
      endcase
   end

   // State and output registers with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!rst) begin
         state        <= GET_A;
         a            <= 32'd0;
         s            <= 1'b0;
         e            <= 10'sd0;
         m            <= 24'd0;
         special      <= 1'b0;
         sat_val      <= 32'd0;
         sat_nv       <= 1'b0;
         sat_nx       <= 1'b0;
         input_a_ack  <= 1'b0;
         output_z_stb <= 1'b0;
         output_z     <= 32'd0;
         output_z_nv  <= 1'b0;
         output_z_nx  <= 1'b0;
      end else begin
         state        <= state_n;
         a            <= a_n;
         s            <= s_n;
         e            <= e_n;
         m            <= m_n;
         special      <= special_n;
         sat_val      <= sat_val_n;
         sat_nv       <= sat_nv_n;
         sat_nx       <= sat_nx_n;
         input_a_ack  <= ack_n;
         output_z_stb <= stb_n;
         output_z     <= z_n;
         output_z_nv  <= nv_n;
         output_z_nx  <= nx_n;
      end
   end

endmodule

// File: tb/tb_fp_to_int.sv
// tb/tb_fp_to_int.sv - scoreboard bench for fp_to_int in signed and unsigned modes
module tb_fp_to_int;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [31:0] a = 32'd0;
   logic        a_stb = 1'b0;
   logic        z_ack = 1'b0;

   logic        a_ack_s, stb_s, nv_s, nx_s;
   logic [31:0] z_s;
   logic        a_ack_u, stb_u, nv_u, nx_u;
   logic [31:0] z_u;

   int tests = 0;
   int fails = 0;

   // each entry: {operand, z, nv, nx}
   logic [65:0] q_s[$];
   logic [65:0] q_u[$];

   always #5 clk = ~clk;

   fp_to_int #(.OUT_UNSIGNED(1'b0)) dut_s (
      .clk(clk), .rst(rst), .input_a(a), .input_a_stb(a_stb), .input_a_ack(a_ack_s),
      .output_z(z_s), .output_z_nv(nv_s), .output_z_nx(nx_s),
      .output_z_stb(stb_s), .output_z_ack(z_ack));

   fp_to_int #(.OUT_UNSIGNED(1'b1)) dut_u (
      .clk(clk), .rst(rst), .input_a(a), .input_a_stb(a_stb), .input_a_ack(a_ack_u),
      .output_z(z_u), .output_z_nv(nv_u), .output_z_nx(nx_u),
      .output_z_stb(stb_u), .output_z_ack(z_ack));

   // Reference conversion through real arithmetic
   function automatic logic [33:0] model(input logic [31:0] f, input bit uns);
      logic [7:0]  ex;
      logic [23:0] mant;
      int          sc;
      real         v;
      logic [31:0] z;
      logic        nv, nx;
      ex = f[30:23];
      z  = 32'd0;
      nv = 1'b0;
      nx = 1'b0;
      if (ex == 8'hFF) begin
         nv = 1'b1;
         if (f[22:0] != 23'd0 || !f[31]) z = uns ? 32'hFFFF_FFFF : 32'h7FFF_FFFF;
         else                            z = uns ? 32'h0000_0000 : 32'h8000_0000;
      end else begin
         mant = {(ex != 8'd0), f[22:0]};
         sc   = (ex == 8'd0) ? -149 : int'(ex) - 150;
         v    = real'(mant) * (2.0 ** sc);
         if (f[31]) v = -v;
         nx = ($floor(v) != v);
         if (!uns) begin
            if (v >= 2147483648.0) begin
               z = 32'h7FFF_FFFF; nv = 1'b1; nx = 1'b0;
            end else if (v < -2147483648.0) begin
               z = 32'h8000_0000; nv = 1'b1; nx = 1'b0;
            end else begin
               z = 32'($rtoi(v));
            end
         end else begin
            if (v >= 4294967296.0) begin
               z = 32'hFFFF_FFFF; nv = 1'b1; nx = 1'b0;
            end else if (v <= -1.0) begin
               z = 32'd0; nv = 1'b1; nx = 1'b0;
            end else if (v < 0.0) begin
               z = 32'd0;
            end else if (v >= 2147483648.0) begin
               z = 32'($rtoi(v - 2147483648.0)) + 32'h8000_0000;
            end else begin
               z = 32'($rtoi(v));
            end
         end
      end
      return {z, nv, nx};
   endfunction

   // Scoreboard: compare both DUTs whenever a result handshake is about to happen
   always @(negedge clk) begin
      logic [65:0] es, eu;
      if (rst && stb_s && z_ack) begin
         tests++;
         if (stb_u !== 1'b1) begin
            fails++;
            $display("FAIL lockstep_stb got stb_u=%b required 1", stb_u);
         end
         if (q_s.size() == 0 || q_u.size() == 0) begin
            fails++;
            $display("FAIL unexpected_output got z_s=%h with empty scoreboard required none", z_s);
         end else begin
            es = q_s.pop_front();
            eu = q_u.pop_front();
            tests++;
            if ({z_s, nv_s, nx_s} !== es[33:0]) begin
               fails++;
               $display("FAIL signed a=%h got z=%h nv=%b nx=%b required z=%h nv=%b nx=%b",
                        es[65:34], z_s, nv_s, nx_s, es[33:2], es[1], es[0]);
            end
            tests++;
            if ({z_u, nv_u, nx_u} !== eu[33:0]) begin
               fails++;
               $display("FAIL unsigned a=%h got z=%h nv=%b nx=%b required z=%h nv=%b nx=%b",
                        eu[65:34], z_u, nv_u, nx_u, eu[33:2], eu[1], eu[0]);
            end
         end
      end
   end

   task automatic send(input logic [31:0] f);
      logic acc;
      acc   = 1'b0;
      a     = f;
      a_stb = 1'b1;
      for (int i = 0; i < 30 && !acc; i++) begin
         @(negedge clk);
         acc = a_ack_s;
         @(posedge clk);
         #1;
      end
      a_stb = 1'b0;
      tests++;
      if (!acc) begin
         fails++;
         $display("FAIL accept_timeout a=%h got no input_a_ack required ack within 30 cycles", f);
      end else begin
         q_s.push_back({f, model(f, 1'b0)});
         q_u.push_back({f, model(f, 1'b1)});
      end
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (q_s.size() != 0 && n < 200) begin
         @(posedge clk);
         #1;
         n++;
      end
      tests++;
      if (q_s.size() != 0) begin
         fails++;
         $display("FAIL drain_timeout got %0d pending required 0", q_s.size());
         q_s.delete();
         q_u.delete();
      end
   endtask

   task automatic test_reset();
      rst = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      tests++;
      if ({a_ack_s, stb_s, z_s, nv_s, nx_s, a_ack_u, stb_u, z_u, nv_u, nx_u} !== 70'd0) begin
         fails++;
         $display("FAIL reset_outputs got ack=%b stb=%b z=%h nv=%b nx=%b required all 0",
                  a_ack_s, stb_s, z_s, nv_s, nx_s);
      end
      rst = 1'b1;
      @(posedge clk);
      #1;
      tests++;
      if (a_ack_s !== 1'b1 || a_ack_u !== 1'b1) begin
         fails++;
         $display("FAIL reset_release_ack got %b/%b required 1", a_ack_s, a_ack_u);
      end
   endtask

   task automatic test_latency();
      int k;
      z_ack = 1'b1;
      send(32'h4000_0000);
      k = 0;
      for (int i = 1; i <= 10 && k == 0; i++) begin
         @(posedge clk);
         #1;
         if (stb_s) k = i;
      end
      tests++;
      if (k != 4) begin
         fails++;
         $display("FAIL stb_latency got %0d edges required 4", k);
      end
      @(posedge clk);
      #1;
      tests++;
      if (stb_s !== 1'b0 || a_ack_s !== 1'b0) begin
         fails++;
         $display("FAIL stb_one_cycle got stb=%b ack=%b required stb=0 ack=0", stb_s, a_ack_s);
      end
      @(posedge clk);
      #1;
      tests++;
      if (a_ack_s !== 1'b1) begin
         fails++;
         $display("FAIL ack_reassert got %b required 1", a_ack_s);
      end
      drain();
   endtask

   task automatic test_vectors();
      logic [31:0] vec[$];
      vec = '{32'hC020_0000, 32'hCF00_0000, 32'h4F32_D05E, 32'h7FC0_0000, 32'h0000_0001,
              32'hBF80_0000, 32'hBF00_0000, 32'h3F80_0000, 32'h8000_0000, 32'h0000_0000,
              32'hFF80_0000, 32'h7F80_0000, 32'h4F00_0000, 32'h4F80_0000, 32'hCF00_0001,
              32'h3FFF_FFFF, 32'h4B7F_FFFF, 32'h8000_0001, 32'h4EFF_FFFF, 32'h4F7F_FFFF};
      z_ack = 1'b1;
      foreach (vec[i]) send(vec[i]);
      drain();
   endtask

   task automatic test_random();
      logic [31:0] f;
      z_ack = 1'b1;
      for (int i = 0; i < 40; i++) begin
         f = {1'($urandom_range(0, 1)), 8'($urandom_range(110, 160)), 23'($urandom)};
         send(f);
      end
      drain();
   endtask

   task automatic test_back_to_back();
      int n;
      z_ack = 1'b1;
      for (int i = 0; i < 6; i++) send(32'h4120_0000 + (i << 20));
      drain();
      n = 0;
      repeat (3) begin
         z_ack = ($urandom_range(0, 1) == 1);
         send(32'hC2F6_8000);
         while (q_s.size() != 0 && n < 100) begin
            z_ack = ($urandom_range(0, 1) == 1);
            @(posedge clk);
            #1;
            n++;
         end
      end
      z_ack = 1'b1;
      drain();
   endtask

   task automatic test_backpressure();
      logic [34:0] snap;
      int k;
      z_ack = 1'b0;
      send(32'h4049_0FDB);
      k = 0;
      for (int i = 0; i < 10 && !stb_s; i++) begin
         @(posedge clk);
         #1;
         k++;
      end
      tests++;
      if (stb_s !== 1'b1) begin
         fails++;
         $display("FAIL bp_stb_timeout got stb=%b required 1", stb_s);
      end
      snap = {stb_s, z_s, nv_s, nx_s};
      for (int i = 0; i < 10; i++) begin
         @(posedge clk);
         #1;
         tests++;
         if ({stb_s, z_s, nv_s, nx_s} !== snap || a_ack_s !== 1'b0) begin
            fails++;
            $display("FAIL bp_hold cycle=%0d got stb=%b z=%h ack=%b required stb=1 z=%h ack=0",
                     i, stb_s, z_s, a_ack_s, snap[33:2]);
         end
      end
      z_ack = 1'b1;
      @(posedge clk);
      #1;
      z_ack = 1'b0;
      tests++;
      if (stb_s !== 1'b0 || a_ack_s !== 1'b0) begin
         fails++;
         $display("FAIL bp_release got stb=%b ack=%b required stb=0 ack=0", stb_s, a_ack_s);
      end
      @(posedge clk);
      #1;
      tests++;
      if (a_ack_s !== 1'b1) begin
         fails++;
         $display("FAIL bp_ack_reassert got %b required 1", a_ack_s);
      end
      tests++;
      if (q_s.size() != 0) begin
         fails++;
         $display("FAIL bp_scoreboard got %0d pending required 0", q_s.size());
         q_s.delete();
         q_u.delete();
      end
   endtask

   task automatic test_reset_mid();
      z_ack = 1'b1;
      send(32'h4000_0000);
      rst = 1'b0;
      @(posedge clk);
      #1;
      q_s.delete();
      q_u.delete();
      tests++;
      if ({a_ack_s, stb_s, z_s, nv_s, nx_s, a_ack_u, stb_u, z_u, nv_u, nx_u} !== 70'd0) begin
         fails++;
         $display("FAIL mid_reset_outputs got ack=%b stb=%b z=%h required all 0", a_ack_s, stb_s, z_s);
      end
      rst = 1'b1;
      @(posedge clk);
      #1;
      tests++;
      if (a_ack_s !== 1'b1) begin
         fails++;
         $display("FAIL mid_reset_ack got %b required 1", a_ack_s);
      end
      tests++;
      if (stb_s !== 1'b0) begin
         fails++;
         $display("FAIL mid_reset_stale_stb got %b required 0", stb_s);
      end
      send(32'h3F80_0000);
      drain();
   endtask

   initial begin
      test_reset();
      test_latency();
      test_vectors();
      test_random();
      test_back_to_back();
      test_backpressure();
      test_reset_mid();
      repeat (5) @(posedge clk);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
